// File: rtl/parity_engine_if.sv
// Handshake and configuration bundle for parity_engine: upstream word and config in,
// downstream word, parity and error status out, plus error-counter clear/readback.
interface parity_engine_if #(
   parameter int DATA_WIDTH    = 8,
   parameter int ERR_CNT_WIDTH = 8
);
   logic                     Par_En;
   logic [1:0]               Par_Type;
   logic                     Mode;
   logic                     In_Valid;
   logic                     In_Ready;
   logic [DATA_WIDTH-1:0]    In_Data;
   logic                     In_Par_Bit;
   logic                     Out_Valid;
   logic                     Out_Ready;
   logic [DATA_WIDTH-1:0]    Out_Data;
   logic                     Out_Par_Bit;
   logic                     Par_Err;
   logic                     Err_Clr;
   logic [ERR_CNT_WIDTH-1:0] Err_Count;

   modport master (
      output Par_En, Par_Type, Mode, In_Valid, In_Data, In_Par_Bit, Out_Ready, Err_Clr,
      input  In_Ready, Out_Valid, Out_Data, Out_Par_Bit, Par_Err, Err_Count
   );

   modport slave (
      input  Par_En, Par_Type, Mode, In_Valid, In_Data, In_Par_Bit, Out_Ready, Err_Clr,
      output In_Ready, Out_Valid, Out_Data, Out_Par_Bit, Par_Err, Err_Count
   );
endinterface

// File: rtl/parity_engine.sv
// Parity generate/check stage, 1-cycle latency into an empty 2-entry buffer; sustains
// 1 word/cycle under backpressure, In_Ready drops only when both entries are occupied.
module parity_engine #(
   parameter int DATA_WIDTH    = 8,
   parameter int ERR_CNT_WIDTH = 8
) (
   input logic             CLK,
   input logic             RST,
   parity_engine_if.slave  bus
);
   typedef struct packed {
      logic [DATA_WIDTH-1:0] data;
      logic                  par;
      logic                  err;
   } entry_t;

   typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

   localparam logic [ERR_CNT_WIDTH-1:0] CNT_MAX = '1;
   localparam logic [ERR_CNT_WIDTH-1:0] CNT_ONE = ERR_CNT_WIDTH'(1);

   state_t                   state, state_nxt;
   entry_t                   head, tail, new_entry;
   logic                     par_calc;
   logic                     accept, deliver;
   logic [ERR_CNT_WIDTH-1:0] err_cnt;

   always_comb begin
      par_calc = 1'b0;
      case (bus.Par_Type)
         2'b00:   par_calc = ^bus.In_Data;
         2'b01:   par_calc = ~^bus.In_Data;
         2'b10:   par_calc = 1'b1;
         default: par_calc = 1'b0;
      endcase
   end

   // Config and received parity bit are captured with the word so later changes cannot touch it.
   always_comb begin
      new_entry.data = bus.In_Data;
      new_entry.par  = bus.Par_En & par_calc;
      new_entry.err  = bus.Par_En & bus.Mode & (bus.In_Par_Bit != par_calc);
   end

   assign bus.In_Ready    = (state != FULL);
   assign bus.Out_Valid   = (state != EMPTY);
   assign bus.Out_Data    = head.data;
   assign bus.Out_Par_Bit = head.par;
   assign bus.Par_Err     = head.err;
   assign bus.Err_Count   = err_cnt;

   assign accept  = bus.In_Valid & bus.In_Ready;
   assign deliver = bus.Out_Valid & bus.Out_Ready;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) state <= EMPTY;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         EMPTY: if (accept) state_nxt = ONE;
         ONE: begin
            if (accept && !deliver)      state_nxt = FULL;
            else if (!accept && deliver) state_nxt = EMPTY;
         end
         FULL:    if (deliver) state_nxt = ONE;
         default: state_nxt = EMPTY;
      endcase
   end

   // head is always the word on Out_*; tail only holds the second word while FULL.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         head <= '0;
         tail <= '0;
      end else begin
         case (state)
            EMPTY: if (accept) head <= new_entry;
            ONE: begin
               if (accept && deliver) head <= new_entry;
               else if (accept)       tail <= new_entry;
            end
            FULL:    if (deliver) head <= tail;
            default: ;
         endcase
      end
   end

   // A clear coinciding with an erroneous accept restarts the count at one.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         err_cnt <= '0;
      end else if (bus.Err_Clr) begin
         err_cnt <= (accept && new_entry.err) ? CNT_ONE : '0;
      end else if (accept && new_entry.err && err_cnt != CNT_MAX) begin
         err_cnt <= err_cnt + CNT_ONE;
      end
   end
endmodule

// File: tb/tb_parity_engine.sv
// Self-checking bench for parity_engine: vector table plus directed sequences,
// with a scoreboard that follows every accepted word to its delivery.
module tb_parity_engine;
   localparam int DW = 8;
   localparam int CW = 2;
   localparam logic [CW-1:0] CNT_MAX = '1;

   logic CLK = 1'b0;
   logic RST = 1'b0;
   always #5 CLK = ~CLK;

   parity_engine_if #(.DATA_WIDTH(DW), .ERR_CNT_WIDTH(CW)) bus ();

   parity_engine #(.DATA_WIDTH(DW), .ERR_CNT_WIDTH(CW)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   typedef struct packed {
      logic [DW-1:0] data;
      logic          par;
      logic          err;
   } sb_t;

   typedef struct packed {
      logic          en;
      logic [1:0]    typ;
      logic          mode;
      logic [DW-1:0] data;
      logic          pb;
      logic          exp_par;
      logic          exp_err;
   } vec_t;

   sb_t           sb_q[$];
   sb_t           exp_e;
   sb_t           held;
   logic          stall_prev = 1'b0;
   logic          exp_par_cur = 1'b0;
   logic          exp_err_cur = 1'b0;
   logic [CW-1:0] exp_cnt = '0;
   int            checks = 0;
   int            errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Scoreboard and error-count model, evaluated mid-cycle ahead of the next rising edge.
   always @(negedge CLK) begin
      if (!RST) begin
         sb_q.delete();
         exp_cnt    = '0;
         stall_prev = 1'b0;
      end else begin
         chk("err_count", 32'(bus.Err_Count), 32'(exp_cnt));
         if (stall_prev) begin
            chk("stall_data", 32'(bus.Out_Data), 32'(held.data));
            chk("stall_par",  32'(bus.Out_Par_Bit), 32'(held.par));
            chk("stall_err",  32'(bus.Par_Err), 32'(held.err));
         end
         if (bus.Out_Valid && bus.Out_Ready) begin
            if (sb_q.size() == 0) begin
               chk("unexpected_out", 32'd1, 32'd0);
            end else begin
               exp_e = sb_q.pop_front();
               chk("out_data", 32'(bus.Out_Data), 32'(exp_e.data));
               chk("out_par",  32'(bus.Out_Par_Bit), 32'(exp_e.par));
               chk("out_err",  32'(bus.Par_Err), 32'(exp_e.err));
            end
         end
         if (bus.In_Valid && bus.In_Ready) begin
            sb_q.push_back({bus.In_Data, exp_par_cur, exp_err_cur});
            if (bus.Err_Clr)                        exp_cnt = exp_err_cur ? CW'(1) : '0;
            else if (exp_err_cur && exp_cnt != CNT_MAX) exp_cnt = exp_cnt + 1'b1;
         end else if (bus.Err_Clr) begin
            exp_cnt = '0;
         end
         stall_prev = bus.Out_Valid && !bus.Out_Ready;
         held       = {bus.Out_Data, bus.Out_Par_Bit, bus.Par_Err};
      end
   end

   task automatic push(input logic en, input logic [1:0] typ, input logic md,
                       input logic [DW-1:0] d, input logic pb, input logic ep, input logic ee);
      int n;
      bus.In_Valid   = 1'b1;
      bus.Par_En     = en;
      bus.Par_Type   = typ;
      bus.Mode       = md;
      bus.In_Data    = d;
      bus.In_Par_Bit = pb;
      exp_par_cur    = ep;
      exp_err_cur    = ee;
      n = 0;
      @(negedge CLK);
      while (!bus.In_Ready && n < 100) begin
         @(negedge CLK);
         n++;
      end
      if (!bus.In_Ready) chk("accept_timeout", 32'd0, 32'd1);
      @(posedge CLK);
      #1;
      bus.In_Valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb_q.size() != 0 && n < 50) begin
         @(posedge CLK);
         #1;
         n++;
      end
      chk("drain", 32'(sb_q.size()), 32'd0);
   endtask

   vec_t vecs[13];
   int   sat_exp[5];

   initial begin
      // en typ mode data pb exp_par exp_err
      vecs[0]  = '{1'b1, 2'b00, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0};
      vecs[1]  = '{1'b1, 2'b00, 1'b0, 8'h07, 1'b0, 1'b1, 1'b0};
      vecs[2]  = '{1'b1, 2'b01, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
      vecs[3]  = '{1'b1, 2'b10, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
      vecs[4]  = '{1'b1, 2'b11, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
      vecs[5]  = '{1'b0, 2'b10, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
      vecs[6]  = '{1'b1, 2'b00, 1'b1, 8'h03, 1'b1, 1'b0, 1'b1};
      vecs[7]  = '{1'b1, 2'b00, 1'b1, 8'h03, 1'b0, 1'b0, 1'b0};
      vecs[8]  = '{1'b1, 2'b01, 1'b1, 8'hFF, 1'b1, 1'b1, 1'b0};
      vecs[9]  = '{1'b1, 2'b10, 1'b1, 8'h12, 1'b0, 1'b1, 1'b1};
      vecs[10] = '{1'b1, 2'b11, 1'b1, 8'h80, 1'b1, 1'b0, 1'b1};
      vecs[11] = '{1'b0, 2'b00, 1'b1, 8'h01, 1'b1, 1'b0, 1'b0};
      vecs[12] = '{1'b1, 2'b00, 1'b0, 8'h01, 1'b0, 1'b1, 1'b0};
      sat_exp  = '{1, 2, 3, 3, 3};

      bus.Par_En = 1'b0; bus.Par_Type = 2'b00; bus.Mode = 1'b0;
      bus.In_Valid = 1'b0; bus.In_Data = '0; bus.In_Par_Bit = 1'b0;
      bus.Out_Ready = 1'b1; bus.Err_Clr = 1'b0;

      #12;
      chk("rst_out_valid", 32'(bus.Out_Valid), 32'd0);
      chk("rst_in_ready",  32'(bus.In_Ready), 32'd1);
      chk("rst_out_data",  32'(bus.Out_Data), 32'd0);
      chk("rst_out_par",   32'(bus.Out_Par_Bit), 32'd0);
      chk("rst_par_err",   32'(bus.Par_Err), 32'd0);
      chk("rst_err_count", 32'(bus.Err_Count), 32'd0);
      @(posedge CLK); #1; RST = 1'b1;

      // Back-to-back generate even, one cycle latency each
      push(1'b1, 2'b00, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0);
      chk("lat_a5_valid", 32'(bus.Out_Valid), 32'd1);
      chk("lat_a5_data",  32'(bus.Out_Data), 32'hA5);
      chk("lat_a5_par",   32'(bus.Out_Par_Bit), 32'd0);
      push(1'b1, 2'b00, 1'b0, 8'h07, 1'b0, 1'b1, 1'b0);
      chk("lat_07_data",  32'(bus.Out_Data), 32'h07);
      chk("lat_07_par",   32'(bus.Out_Par_Bit), 32'd1);
      drain();

      foreach (vecs[i]) begin
         push(vecs[i].en, vecs[i].typ, vecs[i].mode, vecs[i].data, vecs[i].pb,
              vecs[i].exp_par, vecs[i].exp_err);
         chk($sformatf("vec%0d_data", i), 32'(bus.Out_Data), 32'(vecs[i].data));
         chk($sformatf("vec%0d_par", i),  32'(bus.Out_Par_Bit), 32'(vecs[i].exp_par));
         chk($sformatf("vec%0d_err", i),  32'(bus.Par_Err), 32'(vecs[i].exp_err));
      end
      drain();
      chk("table_cnt", 32'(bus.Err_Count), 32'd3);

      // Backpressure: two words fill the buffer, third is held off
      bus.Out_Ready = 1'b0;
      push(1'b1, 2'b00, 1'b0, 8'h11, 1'b0, 1'b0, 1'b0);
      push(1'b1, 2'b01, 1'b0, 8'h22, 1'b0, 1'b1, 1'b0);
      chk("full_in_ready", 32'(bus.In_Ready), 32'd0);
      chk("full_head",     32'(bus.Out_Data), 32'h11);
      fork
         push(1'b1, 2'b10, 1'b0, 8'h33, 1'b0, 1'b1, 1'b0);
         begin
            repeat (3) @(posedge CLK);
            #2;
            chk("held_in_ready",  32'(bus.In_Ready), 32'd0);
            chk("held_out_valid", 32'(bus.Out_Valid), 32'd1);
            chk("held_head",      32'(bus.Out_Data), 32'h11);
            bus.Out_Ready = 1'b1;
         end
      join
      drain();

      // Saturation and clear interaction
      bus.Err_Clr = 1'b1; @(posedge CLK); #1; bus.Err_Clr = 1'b0;
      chk("clr_start", 32'(bus.Err_Count), 32'd0);
      for (int i = 0; i < 5; i++) begin
         push(1'b1, 2'b00, 1'b1, 8'h03, 1'b1, 1'b0, 1'b1);
         chk($sformatf("sat%0d", i), 32'(bus.Err_Count), 32'(sat_exp[i]));
      end
      bus.Err_Clr = 1'b1;
      push(1'b1, 2'b00, 1'b1, 8'h03, 1'b1, 1'b0, 1'b1);
      bus.Err_Clr = 1'b0;
      chk("clr_with_err", 32'(bus.Err_Count), 32'd1);
      bus.Err_Clr = 1'b1; @(posedge CLK); #1; bus.Err_Clr = 1'b0;
      chk("clr_alone", 32'(bus.Err_Count), 32'd0);
      drain();

      // Asynchronous reset with a full buffer
      bus.Out_Ready = 1'b0;
      push(1'b1, 2'b00, 1'b1, 8'h03, 1'b1, 1'b0, 1'b1);
      push(1'b1, 2'b01, 1'b1, 8'h5A, 1'b0, 1'b1, 1'b1);
      chk("pre_rst_full", 32'(bus.In_Ready), 32'd0);
      chk("pre_rst_cnt",  32'(bus.Err_Count), 32'd2);
      @(posedge CLK); #2; RST = 1'b0; #1;
      chk("arst_out_valid", 32'(bus.Out_Valid), 32'd0);
      chk("arst_in_ready",  32'(bus.In_Ready), 32'd1);
      chk("arst_err_count", 32'(bus.Err_Count), 32'd0);
      chk("arst_out_data",  32'(bus.Out_Data), 32'd0);
      @(negedge CLK);
      @(posedge CLK); #1; RST = 1'b1;
      bus.Out_Ready = 1'b1;
      push(1'b1, 2'b00, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0);
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
